// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the router datapath: flit geometry, input port
// numbering, flit type encoding and the output-port FSM state type.
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W  = 16;
  localparam int NUM_IN  = 5;
  localparam int CREDITS = 4;

  // Input port indices into req_i / flit_i / pop_o.
  localparam int N = 0;
  localparam int S = 1;
  localparam int E = 2;
  localparam int W = 3;
  localparam int L = 4;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11   // head and tail in one flit
  } flit_type_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } port_state_t;

  // Flit type lives in the two most significant bits.
  function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_t'(flit[FLIT_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Grants the first requester found
// at or after ptr, wrapping around modulo NUM_IN.
// Ports:
//   req   in  NUM_IN  request vector
//   ptr   in  IDX_W   highest-priority index
//   grant out NUM_IN  one-hot grant (all zero when nothing requests)
//   valid out 1       some request was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic              valid
);

  // Two passes: first the indices from ptr upward, then the wrapped part
  // from 0. The first hit in the first pass always wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (!valid && req[i]) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_port.sv
// -----------------------------------------------------------------------------
// noc_output_port
// Output side of one router port. Drains the per-port input FIFOs through
// their pop interface, arbitrates round-robin among packet heads, keeps the
// port locked to one input from head to tail (wormhole), and drives a flit
// link downstream under credit-based flow control.
// Ports:
//   clk       in  1              clock
//   rst       in  1              asynchronous active-high reset
//   req_i     in  NUM_IN         input i has a head-of-FIFO flit for this port
//   flit_i    in  NUM_IN*FLIT_W  head-of-FIFO flits, slice i = [i*FLIT_W +: FLIT_W]
//   pop_o     out NUM_IN         one-hot pop, flit consumed on this clock edge
//   data_o    out FLIT_W         outgoing flit (holds last value)
//   valid_o   out 1              data_o valid, one cycle per popped flit
//   credit_i  in  1              downstream freed one buffer slot
//   err_o     out 1              sticky protocol error
// -----------------------------------------------------------------------------
module noc_output_port
  import noc_pkg::*;
#(
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int NUM_IN  = noc_pkg::NUM_IN,
  parameter int CREDITS = noc_pkg::CREDITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_i,
  input  logic [NUM_IN*FLIT_W-1:0] flit_i,
  output logic [NUM_IN-1:0]        pop_o,
  output logic [FLIT_W-1:0]        data_o,
  output logic                     valid_o,
  input  logic                     credit_i,
  output logic                     err_o
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);

  typedef logic [IDX_W-1:0] idx_t;

  port_state_t       state_q, state_d;
  idx_t              owner_q, owner_d;
  idx_t              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  credit_cnt_q;

  logic [FLIT_W-1:0] flits [NUM_IN];
  flit_type_t        types [NUM_IN];
  logic [NUM_IN-1:0] eligible;
  logic [NUM_IN-1:0] grant;
  logic              grant_valid;
  idx_t              win_idx;
  logic              credit_ok;
  logic              send;
  logic              err_set;
  logic [FLIT_W-1:0] send_flit;
  flit_type_t        send_type;

  function automatic idx_t next_idx(input idx_t idx);
    return (idx == idx_t'(NUM_IN - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Only packet starts may compete for the port.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign flits[g]    = flit_i[g*FLIT_W +: FLIT_W];
    assign types[g]    = flit_type(flits[g]);
    assign eligible[g] = req_i[g] && (types[g] == HEAD || types[g] == SINGLE);
  end

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) win_idx = idx_t'(i);
    end
  end

  assign credit_ok = (credit_cnt_q != '0);
  assign send      = |pop_o;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: the lock is taken by a HEAD and released by the owner's TAIL;
  // rr_ptr only moves when a packet completes.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (send) begin
      unique case (state_q)
        ST_IDLE: begin
          if (send_type == HEAD) begin
            state_d = ST_LOCKED;
            owner_d = win_idx;
          end else begin
            rr_ptr_d = next_idx(win_idx);
          end
        end
        ST_LOCKED: begin
          if (send_type == TAIL) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_idx(owner_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: pop selection and protocol-error detection. Pops are suppressed
  // while reset is asserted so no flit is consumed that the port cannot send.
  always_comb begin
    pop_o     = '0;
    err_set   = 1'b0;
    send_flit = flits[win_idx];
    send_type = types[win_idx];
    unique case (state_q)
      ST_IDLE: begin
        // A BODY/TAIL at a FIFO head with no open packet is a protocol error.
        for (int i = 0; i < NUM_IN; i++) begin
          if (req_i[i] && !eligible[i]) err_set = 1'b1;
        end
        if (grant_valid && credit_ok && !rst) pop_o = grant;
      end
      ST_LOCKED: begin
        send_flit = flits[owner_q];
        send_type = types[owner_q];
        if (req_i[owner_q]) begin
          if (send_type == HEAD || send_type == SINGLE) begin
            err_set = 1'b1;   // new packet start inside an open packet
          end else if (credit_ok && !rst) begin
            pop_o[owner_q] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Credit counter, error flag and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt_q <= CNT_W'(CREDITS);
      err_o        <= 1'b0;
      valid_o      <= 1'b0;
      // NOTE: the data register is reset as well because data_o has a defined
      // value out of reset; it is a single register, not a storage array.
      data_o       <= '0;
    end else begin
      unique case ({send, credit_i})
        2'b10:   credit_cnt_q <= credit_cnt_q - 1'b1;
        2'b01:   if (credit_cnt_q != CNT_W'(CREDITS)) credit_cnt_q <= credit_cnt_q + 1'b1;
        default: ;
      endcase
      // A returned credit while already full means downstream over-reported.
      err_o   <= err_o | err_set | (credit_i && credit_cnt_q == CNT_W'(CREDITS));
      valid_o <= send;
      if (send) data_o <= send_flit;
    end
  end

endmodule

// File: tb/tb_noc_output_port.sv
module tb_noc_output_port;

  localparam int FW = 16;
  localparam int NI = 5;
  localparam int FD = 16;   // depth of each modelled input FIFO

  logic              clk = 1'b0;
  logic              rst;
  logic [NI-1:0]     req_i;
  logic [NI*FW-1:0]  flit_i;
  logic [NI-1:0]     pop_o;
  logic [FW-1:0]     data_o;
  logic              valid_o;
  logic              credit_i;
  logic              err_o;

  always #5 clk = ~clk;

  noc_output_port dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .flit_i   (flit_i),
    .pop_o    (pop_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .credit_i (credit_i),
    .err_o    (err_o)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [FW-1:0] sb_q [$];
  logic [FW-1:0] exp_flit;

  logic [FW-1:0] fmem [NI][FD];
  int            fhead [NI];
  int            fcnt  [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      req_i[i]          = (fcnt[i] > 0);
      flit_i[i*FW +: FW] = (fcnt[i] > 0) ? fmem[i][fhead[i]] : '0;
    end
  endtask

  task automatic push_flit(input int port, input logic [FW-1:0] f);
    fmem[port][(fhead[port] + fcnt[port]) % FD] = f;
    fcnt[port]++;
    drive();
  endtask

  task automatic flush_fifos();
    for (int i = 0; i < NI; i++) fcnt[i] = 0;
    drive();
  endtask

  // One clock cycle: present credit, check the combinational pop at the
  // falling edge, record the flit that must appear next cycle, then retire
  // the expected pops from the modelled FIFOs after the rising edge.
  task automatic cycle(input string name, input logic [NI-1:0] exp_pop, input logic credit);
    credit_i = credit;
    @(negedge clk);
    check({name, "/pop"}, 32'(pop_o), 32'(exp_pop));
    for (int i = 0; i < NI; i++)
      if (exp_pop[i] && fcnt[i] > 0) sb_q.push_back(fmem[i][fhead[i]]);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (exp_pop[i] && fcnt[i] > 0) begin
        fhead[i] = (fhead[i] + 1) % FD;
        fcnt[i]--;
      end
    end
    credit_i = 1'b0;
    drive();
  endtask

  // Monitor: every valid flit must match the oldest expected flit.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_valid: got data %h, expected no flit", data_o);
      end else begin
        exp_flit = sb_q.pop_front();
        check("data_o", 32'(data_o), 32'(exp_flit));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    credit_i = 1'b0;
    for (int i = 0; i < NI; i++) begin
      fhead[i] = 0;
      fcnt[i]  = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pop",   32'(pop_o),   32'h0);
    check("rst_data",  32'(data_o),  32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_err",   32'(err_o),   32'h0);
    rst = 1'b0;

    // 3-flit packet on N while L waits with a HEAD; credits returned alongside pops.
    push_flit(0, 16'h4001); push_flit(0, 16'h0002); push_flit(0, 16'h8003);
    push_flit(4, 16'h4005); push_flit(4, 16'h8006);
    cycle("pkt_n_head", 5'b00001, 1'b0);   // credits 3
    cycle("pkt_n_body", 5'b00001, 1'b1);   // 3
    cycle("pkt_n_tail", 5'b00001, 1'b1);   // 3, rr_ptr=1
    cycle("pkt_l_head", 5'b10000, 1'b1);
    cycle("pkt_l_tail", 5'b10000, 1'b1);   // rr_ptr=0
    cycle("pkt_idle",   5'b00000, 1'b1);   // credits 4

    // Round robin over five SINGLE sources, N and S holding two each.
    push_flit(0, 16'hC010); push_flit(0, 16'hC011);
    push_flit(1, 16'hC020); push_flit(1, 16'hC021);
    push_flit(2, 16'hC030); push_flit(3, 16'hC040); push_flit(4, 16'hC050);
    cycle("rr_n",    5'b00001, 1'b0);      // credits 3
    cycle("rr_s",    5'b00010, 1'b1);
    cycle("rr_e",    5'b00100, 1'b1);
    cycle("rr_w",    5'b01000, 1'b1);
    cycle("rr_l",    5'b10000, 1'b1);
    cycle("rr_n2",   5'b00001, 1'b1);
    cycle("rr_s2",   5'b00010, 1'b1);      // rr_ptr=2
    cycle("rr_idle", 5'b00000, 1'b1);      // credits 4

    // Single flit on E.
    push_flit(2, 16'hC0AB);
    cycle("single_e",    5'b00100, 1'b0);  // credits 3, rr_ptr=3
    cycle("single_idle", 5'b00000, 1'b1);  // credits 4

    // Credit exhaustion: 6-flit packet on W, L held off by the lock.
    push_flit(3, 16'h4100); push_flit(3, 16'h0101); push_flit(3, 16'h0102);
    push_flit(3, 16'h0103); push_flit(3, 16'h0104); push_flit(3, 16'h8105);
    push_flit(4, 16'hC200); push_flit(4, 16'hC201);
    cycle("cr_w0",     5'b01000, 1'b0);    // 3
    cycle("cr_w1",     5'b01000, 1'b0);    // 2
    cycle("cr_w2",     5'b01000, 1'b0);    // 1
    cycle("cr_w3",     5'b01000, 1'b0);    // 0
    cycle("cr_stall0", 5'b00000, 1'b0);
    cycle("cr_stall1", 5'b00000, 1'b0);
    cycle("cr_pulse",  5'b00000, 1'b1);    // 1
    cycle("cr_w4",     5'b01000, 1'b1);    // stays 1
    cycle("cr_w5",     5'b01000, 1'b0);    // 0, rr_ptr=4
    cycle("cr_l_wait", 5'b00000, 1'b0);
    cycle("cr_pulse2", 5'b00000, 1'b1);    // 1
    cycle("cr_l0",     5'b10000, 1'b1);    // stays 1
    cycle("cr_l1",     5'b10000, 1'b0);    // 0, rr_ptr=0
    repeat (4) cycle("cr_ret", 5'b00000, 1'b1);  // 4

    // BODY flit on E with no open packet.
    check("err_clear", 32'(err_o), 32'h0);
    push_flit(2, 16'h0AAA);
    cycle("err_body", 5'b00000, 1'b0);
    check("err_body_flag", 32'(err_o), 32'h1);
    cycle("err_body_hold", 5'b00000, 1'b0);
    flush_fifos();
    cycle("err_idle", 5'b00000, 1'b0);
    check("err_sticky", 32'(err_o), 32'h1);

    // Reset after 2 of 4 flits of an N packet; a new S packet waits through reset.
    push_flit(0, 16'h4300); push_flit(0, 16'h0301);
    push_flit(0, 16'h0302); push_flit(0, 16'h8303);
    cycle("mid_head", 5'b00001, 1'b0);
    cycle("mid_body", 5'b00001, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    flush_fifos();
    push_flit(1, 16'h4400); push_flit(1, 16'h8401);
    #1;
    check("mid_rst_pop",   32'(pop_o),   32'h0);
    check("mid_rst_valid", 32'(valid_o), 32'h0);
    check("mid_rst_data",  32'(data_o),  32'h0);
    check("mid_rst_err",   32'(err_o),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("post_rst_head", 5'b00010, 1'b0); // credits 3
    cycle("post_rst_tail", 5'b00010, 1'b0); // 2, rr_ptr=2
    check("post_rst_err", 32'(err_o), 32'h0);
    cycle("post_rst_ret0", 5'b00000, 1'b1);
    cycle("post_rst_ret1", 5'b00000, 1'b1); // 4

    // Credit returned while already full: error, count stays at 4.
    cycle("cr_full", 5'b00000, 1'b1);
    check("err_credit_full", 32'(err_o), 32'h1);
    push_flit(2, 16'hC300); push_flit(2, 16'hC301); push_flit(2, 16'hC302);
    push_flit(2, 16'hC303); push_flit(2, 16'hC304);
    cycle("full_p0", 5'b00100, 1'b0);
    cycle("full_p1", 5'b00100, 1'b0);
    cycle("full_p2", 5'b00100, 1'b0);
    cycle("full_p3", 5'b00100, 1'b0);
    cycle("full_stall", 5'b00000, 1'b0);
    flush_fifos();
    cycle("drain0", 5'b00000, 1'b0);
    cycle("drain1", 5'b00000, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
